// File: rtl/seq_mult_4b_pkg.sv
// Shared types and constants for the 4-bit
// shift-and-add multiplier.
package seq_mult_4b_pkg;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_mult_4b_rca.sv
// 4-bit ripple-carry adder used for the
// multiplier's add step.
module RCA_4b (
  output logic [3:0] sum,
  output logic       c_out,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in
);

  logic [4:0] w_c;

  always_comb begin
    w_c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) |
                 (w_c[i] & (a[i] ^ b[i]));
    end
    c_out = w_c[4];
  end

endmodule

// File: rtl/seq_mult_4b.sv
// Sequential unsigned 4x4 multiplier,
// one shift-and-add step per clock.
module seq_mult_4b
  import seq_mult_4b_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*WIDTH-1:0] product
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_m;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_a_nxt;
  logic [WIDTH-1:0]   w_q_nxt;

  assign w_b = r_q[0] ? r_m : '0;

  RCA_4b u_rca (
    .sum   (w_sum),
    .c_out (w_cout),
    .a     (r_a),
    .b     (w_b),
    .c_in  (1'b0)
  );

  // The carry shifts into A's MSB, so it is never lost.
  assign w_a_nxt = {w_cout, w_sum[WIDTH-1:1]};
  assign w_q_nxt = {w_sum[0], r_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_m     <= multiplicand;
            r_q     <= multiplier;
            r_a     <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            product <= {w_a_nxt, w_q_nxt};
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_4b.sv
// Directed self-checking bench for
// seq_mult_4b.
module tb_seq_mult_4b;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] mc;
  logic [3:0] mp;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks = 0;
  int fails  = 0;
  int ovl    = 0;

  always #5 clk = ~clk;

  seq_mult_4b dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mc),
    .multiplier   (mp),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic run_mult(input  logic [3:0] a,
                          input  logic [3:0] b,
                          output logic [7:0] p,
                          output int bcyc,
                          output int dcyc,
                          output logic dlate);
    @(negedge clk);
    start = 1'b1;
    mc    = a;
    mp    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    mc    = 4'($urandom);
    mp    = 4'($urandom);
    bcyc  = 0;
    dcyc  = 0;
    p     = '0;
    for (int i = 1; i <= 12 && dcyc == 0; i++) begin
      @(negedge clk);
      if (busy && done) ovl++;
      if (busy) bcyc++;
      if (done) begin
        dcyc = i;
        p    = product;
      end
    end
    @(negedge clk);
    dlate = done;
  endtask

  logic [7:0] p;
  int         bc;
  int         dc;
  logic       dl;
  int         last;
  int         npulse;
  int         nd;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mc    = '0;
    mp    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_prod", 32'(product), 0);

    run_mult(4'd3, 4'd5, p, bc, dc, dl);
    chk("3x5_prod", 32'(p), 32'h0F);
    chk("3x5_busy", 32'(bc), 4);
    chk("3x5_dcyc", 32'(dc), 5);
    chk("3x5_dlen", 32'(dl), 0);

    run_mult(4'd15, 4'd15, p, bc, dc, dl);
    chk("15x15", 32'(p), 32'hE1);
    run_mult(4'd0, 4'd9, p, bc, dc, dl);
    chk("0x9", 32'(p), 32'h00);
    run_mult(4'd9, 4'd0, p, bc, dc, dl);
    chk("9x0", 32'(p), 32'h00);

    // start held high; operands scrambled while busy
    @(negedge clk);
    start  = 1'b1;
    mc     = 4'd6;
    mp     = 4'd7;
    last   = -1;
    npulse = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy && done) ovl++;
      if (done) begin
        npulse++;
        chk("hold_prod", 32'(product), 32'h2A);
        if (last >= 0)
          chk("hold_ival", 32'(i - last), 6);
        last = i;
      end
      if (busy) begin
        mc = 4'd15;
        mp = 4'd9;
      end else begin
        mc = 4'd6;
        mp = 4'd7;
      end
    end
    start = 1'b0;
    chk("hold_npulse", 32'(npulse), 5);
    repeat (3) @(negedge clk);

    // reset during the 2nd CALC cycle
    @(negedge clk);
    start = 1'b1;
    mc    = 4'd12;
    mp    = 4'd11;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_prod", 32'(product), 0);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("mid_idle", 32'(nd), 0);
    run_mult(4'd12, 4'd11, p, bc, dc, dl);
    chk("12x11", 32'(p), 32'h84);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_mult(4'(a), 4'(b), p, bc, dc, dl);
        chk("sw_prod", 32'(p), 32'(a * b));
        chk("sw_dcyc", 32'(dc), 5);
        chk("sw_dlen", 32'(dl), 0);
      end
    end
    chk("no_overlap", 32'(ovl), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
